// File: rtl/cpu_control_unit.sv
// cpu_control_unit: PC, instruction fetch handshake, decode and IDLE/FETCH/EXEC/WB sequencing.
// Define CTRL_BNE_EN to decode opcode 0x08 as bne; otherwise 0x08 is an undefined opcode.
module cpu_control_unit #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [31:0]     INSTRUCTION,
  input  logic            IMEM_READY,
  input  logic            ZERO,
  output logic            IMEM_REQ,
  output logic [PC_W-1:0] PC,
  output logic [2:0]      INADDRESS,
  output logic [2:0]      OUT1ADDRESS,
  output logic [2:0]      OUT2ADDRESS,
  output logic            WRITE,
  output logic [7:0]      IMMEDIATE,
  output logic            IMM_SEL,
  output logic            NEG_SEL,
  output logic [2:0]      ALUOP,
  output logic            ILLEGAL
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;
  typedef enum logic [1:0] {BR_NONE, BR_ALW, BR_EQ, BR_NE} br_t;
  state_t          state_q;
  br_t             br_q, br_d;
  logic [PC_W-1:0] pc_q, off;
  logic [7:0]      dst_q, imm_q;
  logic [2:0]      src1_q, alu_q, alu_d;
  logic            req_q, wr_q, wen_q, wen_d, isel_q, isel_d, neg_q, neg_d, ill_q, ill_d, taken_q;
  logic            unused_src1_hi;
  assign unused_src1_hi = ^INSTRUCTION[15:11];
  // Branch displacement is a signed word offset held in the DEST field.
  assign off = {{(PC_W-10){dst_q[7]}}, dst_q, 2'b00};
  always_comb begin
    isel_d = 1'b0;
    neg_d  = 1'b0;
    alu_d  = 3'd0;
    wen_d  = 1'b0;
    br_d   = BR_NONE;
    ill_d  = 1'b0;
    case (INSTRUCTION[31:24])
      8'h00: begin isel_d = 1'b1; wen_d = 1'b1; end
      8'h01: wen_d = 1'b1;
      8'h02: begin alu_d = 3'd1; wen_d = 1'b1; end
      8'h03: begin alu_d = 3'd1; neg_d = 1'b1; wen_d = 1'b1; end
      8'h04: begin alu_d = 3'd2; wen_d = 1'b1; end
      8'h05: begin alu_d = 3'd3; wen_d = 1'b1; end
      8'h06: br_d = BR_ALW;
      8'h07: begin alu_d = 3'd1; neg_d = 1'b1; br_d = BR_EQ; end
`ifdef CTRL_BNE_EN
      8'h08: begin alu_d = 3'd1; neg_d = 1'b1; br_d = BR_NE; end
`endif
      default: ill_d = 1'b1;
    endcase
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      wen_q   <= 1'b0;
      dst_q   <= '0;
      src1_q  <= '0;
      imm_q   <= '0;
      isel_q  <= 1'b0;
      neg_q   <= 1'b0;
      alu_q   <= '0;
      br_q    <= BR_NONE;
      taken_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
        end
        FETCH: if (IMEM_READY) begin
          state_q <= EXEC;
          req_q   <= 1'b0;
          dst_q   <= ill_d ? 8'd0 : INSTRUCTION[23:16];
          src1_q  <= ill_d ? 3'd0 : INSTRUCTION[10:8];
          imm_q   <= ill_d ? 8'd0 : INSTRUCTION[7:0];
          isel_q  <= isel_d;
          neg_q   <= neg_d;
          alu_q   <= alu_d;
          wen_q   <= wen_d;
          br_q    <= br_d;
          ill_q   <= ill_q | ill_d;
        end
        EXEC: begin
          state_q <= WB;
          wr_q    <= wen_q;
          taken_q <= (br_q == BR_ALW) || (br_q == BR_EQ && ZERO) || (br_q == BR_NE && !ZERO);
        end
        WB: begin
          state_q <= FETCH;
          wr_q    <= 1'b0;
          req_q   <= 1'b1;
          pc_q    <= pc_q + PC_W'(4) + (taken_q ? off : '0);
        end
      endcase
    end
  end
  assign IMEM_REQ    = req_q;
  assign PC          = pc_q;
  assign INADDRESS   = dst_q[2:0];
  assign OUT1ADDRESS = src1_q;
  assign OUT2ADDRESS = imm_q[2:0];
  assign WRITE       = wr_q;
  assign IMMEDIATE   = imm_q;
  assign IMM_SEL     = isel_q;
  assign NEG_SEL     = neg_q;
  assign ALUOP       = alu_q;
  assign ILLEGAL     = ill_q;
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed instruction vectors with a queue-based scoreboard and a decoupled monitor.
module tb_cpu_control_unit;
  logic        CLK = 1'b0, RESET = 1'b1, IMEM_READY = 1'b0, ZERO = 1'b0;
  logic [31:0] INSTRUCTION = '0;
  logic        IMEM_REQ, WRITE, IMM_SEL, NEG_SEL, ILLEGAL;
  logic [31:0] PC;
  logic [2:0]  INADDRESS, OUT1ADDRESS, OUT2ADDRESS, ALUOP;
  logic [7:0]  IMMEDIATE;

  cpu_control_unit #(.PC_W(32), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .IMEM_READY(IMEM_READY), .ZERO(ZERO),
    .IMEM_REQ(IMEM_REQ), .PC(PC), .INADDRESS(INADDRESS), .OUT1ADDRESS(OUT1ADDRESS),
    .OUT2ADDRESS(OUT2ADDRESS), .WRITE(WRITE), .IMMEDIATE(IMMEDIATE), .IMM_SEL(IMM_SEL),
    .NEG_SEL(NEG_SEL), .ALUOP(ALUOP), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] ins;
    logic        z;
    int          dly;
    logic [2:0]  ina, o1, o2;
    logic [7:0]  imm;
    logic        isel, neg;
    logic [2:0]  alu;
    logic        wr;
    logic [31:0] pc;
    logic        ill;
  } vec_t;

  typedef struct {
    vec_t        v;
    logic [31:0] pc0;
  } exp_t;

  exp_t        q[$];
  vec_t        tbl[12];
  int          n_vec = 0, n_err = 0;
  bit          mon_en = 1'b1;
  logic [31:0] pc_m = '0;

  function automatic vec_t mk(input logic [31:0] ins, input logic z, input int dly,
                              input logic [2:0] ina, input logic [2:0] o1, input logic [2:0] o2,
                              input logic [7:0] imm, input logic isel, input logic neg,
                              input logic [2:0] alu, input logic wr, input logic [31:0] pc,
                              input logic ill);
    vec_t v;
    v.ins = ins; v.z = z; v.dly = dly; v.ina = ina; v.o1 = o1; v.o2 = o2; v.imm = imm;
    v.isel = isel; v.neg = neg; v.alu = alu; v.wr = wr; v.pc = pc; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: each handshake opens a transaction observed over EXEC, WB and the following FETCH.
  logic [2:0]  m_ina, m_o1, m_o2, m_alu;
  logic [7:0]  m_imm;
  logic        m_isel, m_neg, m_ill, m_we, m_ww, m_wa;
  logic [31:0] m_pe, m_pw, m_pa;
  bit          m_skip = 1'b0;
  exp_t        m_e;
  initial begin
    forever begin
      if (!m_skip) @(negedge CLK);
      m_skip = 1'b0;
      if (mon_en && !RESET && IMEM_REQ && IMEM_READY) begin
        @(negedge CLK);
        m_ina = INADDRESS; m_o1 = OUT1ADDRESS; m_o2 = OUT2ADDRESS; m_imm = IMMEDIATE;
        m_isel = IMM_SEL; m_neg = NEG_SEL; m_alu = ALUOP; m_ill = ILLEGAL; m_we = WRITE; m_pe = PC;
        @(negedge CLK);
        m_ww = WRITE; m_pw = PC;
        @(negedge CLK);
        m_wa = WRITE; m_pa = PC;
        m_skip = 1'b1;
        if (q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_instr: got a handshake with no expected entry");
        end else begin
          m_e = q.pop_front();
          chk("inaddress", m_ina, m_e.v.ina);
          chk("out1address", m_o1, m_e.v.o1);
          chk("out2address", m_o2, m_e.v.o2);
          chk("immediate", m_imm, m_e.v.imm);
          chk("imm_sel", m_isel, m_e.v.isel);
          chk("neg_sel", m_neg, m_e.v.neg);
          chk("aluop", m_alu, m_e.v.alu);
          chk("illegal", m_ill, m_e.v.ill);
          chk("write_exec", m_we, 0);
          chk("write_wb", m_ww, m_e.v.wr);
          chk("write_after", m_wa, 0);
          chk("pc_exec", m_pe, m_e.pc0);
          chk("pc_wb", m_pw, m_e.pc0);
          chk("pc_next", m_pa, m_e.v.pc);
        end
      end
    end
  end

  task automatic issue(input vec_t v, input logic [2:0] prev_ina, input bit push);
    int   k = 0;
    exp_t e;
    do begin @(posedge CLK); #1; k++; end while (!IMEM_REQ && k < 20);
    chk("fetch_req", IMEM_REQ, 1);
    INSTRUCTION = v.ins;
    ZERO = v.z;
    e.v = v; e.pc0 = pc_m;
    if (push) q.push_back(e);
    for (int i = 0; i < v.dly; i++) begin
      @(negedge CLK);
      chk("stall_req", IMEM_REQ, 1);
      chk("stall_pc", PC, pc_m);
      chk("stall_ina", INADDRESS, prev_ina);
      chk("stall_write", WRITE, 0);
      @(posedge CLK); #1;
    end
    IMEM_READY = 1'b1;
    @(posedge CLK); #1;
    IMEM_READY = 1'b0;
    chk("req_drop", IMEM_REQ, 0);
    pc_m = v.pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    //           ins          z  dly ina o1 o2 imm    isel neg alu wr pc            ill
    tbl[0]  = mk(32'h0004002A, 0, 0, 4, 0, 2, 8'h2A, 1, 0, 0, 1, 32'h00000004, 0);
    tbl[1]  = mk(32'h03010203, 0, 0, 1, 2, 3, 8'h03, 0, 1, 1, 1, 32'h00000008, 0);
    tbl[2]  = mk(32'h07FE0000, 1, 0, 6, 0, 0, 8'h00, 0, 1, 1, 0, 32'h00000004, 0);
    tbl[3]  = mk(32'h01050600, 0, 0, 5, 6, 0, 8'h00, 0, 0, 0, 1, 32'h00000008, 0);
    tbl[4]  = mk(32'h07FE0000, 0, 0, 6, 0, 0, 8'h00, 0, 1, 1, 0, 32'h0000000C, 0);
    tbl[5]  = mk(32'h04020304, 0, 4, 2, 3, 4, 8'h04, 0, 0, 2, 1, 32'h00000010, 0);
    tbl[6]  = mk(32'h05070607, 0, 0, 7, 6, 7, 8'h07, 0, 0, 3, 1, 32'h00000014, 0);
    tbl[7]  = mk(32'h06FF0000, 0, 0, 7, 0, 0, 8'h00, 0, 0, 0, 0, 32'h00000014, 0);
    tbl[8]  = mk(32'h06800000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 32'hFFFFFE18, 0);
    tbl[9]  = mk(32'hFF000000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 32'hFFFFFE1C, 1);
    tbl[10] = mk(32'h02030102, 0, 0, 3, 1, 2, 8'h02, 0, 0, 1, 1, 32'hFFFFFE20, 1);
`ifdef CTRL_BNE_EN
    tbl[11] = mk(32'h08FE0000, 0, 0, 6, 0, 0, 8'h00, 0, 1, 1, 0, 32'hFFFFFE1C, 1);
`else
    tbl[11] = mk(32'h08FE0000, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 32'hFFFFFE24, 1);
`endif
    INSTRUCTION = tbl[0].ins;
    IMEM_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_pc", PC, 0);
    chk("rst_req", IMEM_REQ, 0);
    chk("rst_write", WRITE, 0);
    chk("rst_ina", INADDRESS, 0);
    chk("rst_o1", OUT1ADDRESS, 0);
    chk("rst_o2", OUT2ADDRESS, 0);
    chk("rst_imm", IMMEDIATE, 0);
    chk("rst_isel", IMM_SEL, 0);
    chk("rst_neg", NEG_SEL, 0);
    chk("rst_alu", ALUOP, 0);
    chk("rst_ill", ILLEGAL, 0);
    begin
      exp_t e;
      e.v = tbl[0]; e.pc0 = 32'h0;
      q.push_back(e);
    end
    RESET = 1'b0;
    @(negedge CLK);
    chk("idle_req", IMEM_REQ, 0);
    @(posedge CLK); #1;
    chk("first_req", IMEM_REQ, 1);
    @(posedge CLK); #1;
    IMEM_READY = 1'b0;
    chk("first_req_drop", IMEM_REQ, 0);
    pc_m = tbl[0].pc;
    for (int i = 1; i < 12; i++) issue(tbl[i], tbl[i-1].ina, 1'b1);
    // Reset asserted in the WB cycle of an add: the writeback must vanish without a clock edge.
    mon_en = 1'b0;
    issue(tbl[10], tbl[11].ina, 1'b0);
    @(posedge CLK); #1;
    chk("wb_write_pre_reset", WRITE, 1);
    #2 RESET = 1'b1;
    #1;
    chk("async_write", WRITE, 0);
    chk("async_pc", PC, 0);
    chk("async_req", IMEM_REQ, 0);
    chk("async_ill", ILLEGAL, 0);
    chk("async_ina", INADDRESS, 0);
    chk("async_alu", ALUOP, 0);
    @(posedge CLK);
    chk("write_at_edge_in_reset", WRITE, 0);
    #1 RESET = 1'b0;
    pc_m = 32'h0;
    @(negedge CLK);
    chk("restart_idle_req", IMEM_REQ, 0);
    mon_en = 1'b1;
    issue(tbl[0], 3'd0, 1'b1);
    repeat (6) @(posedge CLK);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
